dff_response_checker: RTL and testbench
=======================================

Name: dff_response_checker

Overview:
- Response-side counterpart to the team's D flip-flop stimulus benches: a synthesizable checker.
- Watches the stimulus bit D and the flip-flop outputs Q/Qn, predicts Q from D delayed by LATENCY clocks, and flags mismatches.
- Counts checked cycles and errors, and reports PASS/DONE after NUM_CHECKS comparisons.
- Sits beside the DUT in self-checking benches and on FPGA lab boards.

Parameters:
CNT_W, 8, width of CHK_CNT and ERR_CNT
NUM_CHECKS, 16, compares per run (1 .. 2^CNT_W-1)
LATENCY, 1, DUT delay D->Q in clocks (1..4)

Ports:
CLK  input  1  clock, rising edge
CLR  input  1  asynchronous active-high reset
START  input  1  one-cycle pulse; begins/restarts a run
EN  input  1  check enable; 0 pauses the run
D  input  1  stimulus bit driven into DUT
Q  input  1  DUT true output
Qn  input  1  DUT complement output
ERR  output  1  one-cycle pulse per mismatching compare
FAIL  output  1  sticky; set on first mismatch of a run
DONE  output  1  run complete
PASS  output  1  DONE and ERR_CNT==0
CHK_CNT  output  CNT_W  compares performed, saturating
ERR_CNT  output  CNT_W  mismatches seen, saturating

Behaviour:
- CLR=1 (async, any time): state IDLE; ERR, FAIL, DONE, PASS, CHK_CNT, ERR_CNT=0; expected pipe EXP[LATENCY-1:0]=0; valid pipe VLD=0. Effect is immediate, not at the next edge.
- All outputs are registered; state updates on the rising CLK edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - START=1 -> RUN.
  - On the same edge, clear counters, FAIL, ERR and VLD.
  - Load EXP[0]=D, VLD[0]=1 if EN=1.
- RUN, EN=1, each edge:
  - EXP shifts: EXP[0]<=D, EXP[i]<=EXP[i-1].
  - VLD shifts in 1.
  - If VLD[LATENCY-1]=1, a compare occurs using the pre-edge values of EXP[LATENCY-1], Q and Qn.
- RUN, EN=0: EXP, VLD and counters hold; no compare; ERR=0.
- Compare:
  - Mismatch = (Q != EXP[LATENCY-1]) OR (Qn != ~Q).
  - CHK_CNT += 1; on mismatch ERR_CNT += 1, ERR=1 for exactly one cycle, FAIL=1.
  - Otherwise ERR=0.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Completion:
  - When a compare makes CHK_CNT == NUM_CHECKS, go to DONE on that edge.
  - DONE=1 from the next cycle.
  - PASS = (ERR_CNT==0), registered alongside DONE.
- DONE:
  - Counters, FAIL and PASS frozen; ERR=0; D/Q ignored.
  - START=1 -> RUN with the same clearing as from IDLE; DONE and PASS drop on that edge.
- START=1 while in RUN: restart.
  - Counters, FAIL and VLD clear; EXP[0] loads D.
  - The START edge produces no compare, even if VLD was full.
- START and EN both 0 in IDLE: remain IDLE; D/Q ignored.
- First LATENCY enabled cycles after START are fill cycles with no compare, so DUT reset/fill transients are ignored.
- ERR is never asserted in IDLE or DONE.

Test Plan:
- LATENCY=1, NUM_CHECKS=8. CLR=1 for 12 units, release, START pulse, EN=1. Drive D=1,0,1,1,0,1,0,1 with Q=D delayed 1 clock, Qn=~Q -> ERR never 1; CHK_CNT reaches 8; DONE=1, PASS=1, ERR_CNT=0.
- Same run, force Q=0 on the compare expecting 1 at check 3 -> ERR high exactly one cycle; FAIL=1 thereafter; ERR_CNT=1; DONE=1 with PASS=0 after 8 checks.
- Qn stuck equal to Q for 2 compares -> ERR_CNT=2, FAIL=1, even though Q matches expected.
- EN=0 for 5 cycles mid-run while Q toggles wrongly -> CHK_CNT and ERR_CNT unchanged during the gap; ERR=0; run resumes and completes with PASS=1.
- Assert CLR for 3 units mid-run with CHK_CNT=5 (async, between edges) -> all outputs 0 immediately; state IDLE; a new START gives a fresh 8-check run.
- CNT_W=2, NUM_CHECKS=3, Q always wrong; then a START pulse in DONE -> ERR_CNT=3 (saturation value), DONE=1, PASS=0; after START, counters=0, DONE=0, state RUN.

Source files
------------

// File: rtl/dff_response_checker.sv
// Checks a D flip-flop's Q/Qn against D delayed by LATENCY clocks.
// Counts compares and mismatches, then reports DONE/PASS after NUM_CHECKS compares.
module dff_response_checker #(
   parameter int CNT_W      = 8,
   parameter int NUM_CHECKS = 16,
   parameter int LATENCY    = 1
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             START,
   input  logic             EN,
   input  logic             D,
   input  logic             Q,
   input  logic             Qn,
   output logic             ERR,
   output logic             FAIL,
   output logic             DONE,
   output logic             PASS,
   output logic [CNT_W-1:0] CHK_CNT,
   output logic [CNT_W-1:0] ERR_CNT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_CHECKS);

   state_t             r_state, w_state_nxt;
   logic [LATENCY-1:0] r_exp, r_vld, w_exp_nxt, w_vld_nxt, w_exp_sh, w_vld_sh;
   logic               r_err, r_fail, r_done, r_pass;
   logic               w_err_nxt, w_fail_nxt, w_done_nxt, w_pass_nxt;
   logic [CNT_W-1:0]   r_chk, r_ecnt, w_chk_nxt, w_ecnt_nxt, w_chk_inc, w_ecnt_inc;
   logic               w_mis;

   assign w_exp_sh   = (r_exp << 1) | LATENCY'(D);
   assign w_vld_sh   = (r_vld << 1) | LATENCY'(1'b1);
   assign w_mis      = (Q != r_exp[LATENCY-1]) || (Qn == Q);
   assign w_chk_inc  = (r_chk  == '1) ? r_chk  : r_chk  + CNT_W'(1);
   assign w_ecnt_inc = (r_ecnt == '1) ? r_ecnt : r_ecnt + CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_exp_nxt   = r_exp;
      w_vld_nxt   = r_vld;
      w_err_nxt   = 1'b0;
      w_fail_nxt  = r_fail;
      w_done_nxt  = r_done;
      w_pass_nxt  = r_pass;
      w_chk_nxt   = r_chk;
      w_ecnt_nxt  = r_ecnt;

      // START wins in every state; its edge never compares, even with a full valid pipe.
      if (START) begin
         w_state_nxt = S_RUN;
         w_exp_nxt   = w_exp_sh;
         w_vld_nxt   = EN ? LATENCY'(1'b1) : '0;
         w_fail_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         w_pass_nxt  = 1'b0;
         w_chk_nxt   = '0;
         w_ecnt_nxt  = '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (EN) begin
                  w_exp_nxt = w_exp_sh;
                  w_vld_nxt = w_vld_sh;
                  if (r_vld[LATENCY-1]) begin
                     w_chk_nxt = w_chk_inc;
                     if (w_mis) begin
                        w_ecnt_nxt = w_ecnt_inc;
                        w_err_nxt  = 1'b1;
                        w_fail_nxt = 1'b1;
                     end
                     if (w_chk_nxt == LP_NUM) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_ecnt_nxt == '0);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= S_IDLE;
         r_exp   <= '0;
         r_vld   <= '0;
         r_err   <= 1'b0;
         r_fail  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_chk   <= '0;
         r_ecnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_exp   <= w_exp_nxt;
         r_vld   <= w_vld_nxt;
         r_err   <= w_err_nxt;
         r_fail  <= w_fail_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_chk   <= w_chk_nxt;
         r_ecnt  <= w_ecnt_nxt;
      end
   end

   assign ERR     = r_err;
   assign FAIL    = r_fail;
   assign DONE    = r_done;
   assign PASS    = r_pass;
   assign CHK_CNT = r_chk;
   assign ERR_CNT = r_ecnt;

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: vector table plus hand-written corner sequences.
module tb_dff_response_checker;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       s_start = 1'b0, s_en = 1'b0, s_d = 1'b0;
   logic       s_qf = 1'b0, s_qv = 1'b0, s_qns = 1'b0;
   logic       dff_q = 1'b0;
   logic       w_q, w_qn;
   logic       ERR, FAIL, DONE, PASS;
   logic [7:0] CHK_CNT, ERR_CNT;

   logic       s2_start = 1'b0, s2_en = 1'b1, s2_d = 1'b1, s2_q = 1'b0, s2_qn = 1'b1;
   logic       ERR2, FAIL2, DONE2, PASS2;
   logic [1:0] CHK2, ECNT2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   // Behavioural flip-flop under test; Q/Qn can be corrupted on demand.
   always @(posedge CLK) dff_q <= s_d;
   assign w_q  = s_qf ? s_qv : dff_q;
   assign w_qn = s_qns ? w_q : ~w_q;

   dff_response_checker #(.CNT_W(8), .NUM_CHECKS(8), .LATENCY(1)) u_dut (
      .CLK(CLK), .CLR(CLR), .START(s_start), .EN(s_en), .D(s_d), .Q(w_q), .Qn(w_qn),
      .ERR(ERR), .FAIL(FAIL), .DONE(DONE), .PASS(PASS), .CHK_CNT(CHK_CNT), .ERR_CNT(ERR_CNT)
   );

   dff_response_checker #(.CNT_W(2), .NUM_CHECKS(3), .LATENCY(1)) u_sat (
      .CLK(CLK), .CLR(CLR), .START(s2_start), .EN(s2_en), .D(s2_d), .Q(s2_q), .Qn(s2_qn),
      .ERR(ERR2), .FAIL(FAIL2), .DONE(DONE2), .PASS(PASS2), .CHK_CNT(CHK2), .ERR_CNT(ECNT2)
   );

   typedef struct {
      logic st, en, d, qf, qv, qns;
      logic e_err, e_fail, e_done, e_pass;
      int   e_chk, e_ec;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic st, en, d, qf, qv, qns,
                               input logic e_err, e_fail, e_done, e_pass,
                               input int e_chk, e_ec);
      vec_t v;
      v.st = st; v.en = en; v.d = d; v.qf = qf; v.qv = qv; v.qns = qns;
      v.e_err = e_err; v.e_fail = e_fail; v.e_done = e_done; v.e_pass = e_pass;
      v.e_chk = e_chk; v.e_ec = e_ec;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      n_assert++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic step(input logic st, en, d, qf, qv, qns);
      s_start = st; s_en = en; s_d = d; s_qf = qf; s_qv = qv; s_qns = qns;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic e_err, e_fail, e_done, e_pass,
                          input int e_chk, e_ec);
      chk({nm, "_err"},  ERR,     e_err);
      chk({nm, "_fail"}, FAIL,    e_fail);
      chk({nm, "_done"}, DONE,    e_done);
      chk({nm, "_pass"}, PASS,    e_pass);
      chk({nm, "_chk"},  CHK_CNT, e_chk);
      chk({nm, "_ec"},   ERR_CNT, e_ec);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Clean run from IDLE: D = 1,0,1,1,0,1,0,1
      add(1,1,1,0,0,0, 0,0,0,0, 0,0);
      add(0,1,0,0,0,0, 0,0,0,0, 1,0);
      add(0,1,1,0,0,0, 0,0,0,0, 2,0);
      add(0,1,1,0,0,0, 0,0,0,0, 3,0);
      add(0,1,0,0,0,0, 0,0,0,0, 4,0);
      add(0,1,1,0,0,0, 0,0,0,0, 5,0);
      add(0,1,0,0,0,0, 0,0,0,0, 6,0);
      add(0,1,1,0,0,0, 0,0,0,0, 7,0);
      add(0,1,0,0,0,0, 0,0,1,1, 8,0);
      add(0,1,1,0,0,0, 0,0,1,1, 8,0);
      // Restart from DONE; Q forced to 0 on the third compare (expects 1)
      add(1,1,1,0,0,0, 0,0,0,0, 0,0);
      add(0,1,0,0,0,0, 0,0,0,0, 1,0);
      add(0,1,1,0,0,0, 0,0,0,0, 2,0);
      add(0,1,1,1,0,0, 1,1,0,0, 3,1);
      add(0,1,0,0,0,0, 0,1,0,0, 4,1);
      add(0,1,1,0,0,0, 0,1,0,0, 5,1);
      add(0,1,0,0,0,0, 0,1,0,0, 6,1);
      add(0,1,1,0,0,0, 0,1,0,0, 7,1);
      add(0,1,0,0,0,0, 0,1,1,0, 8,1);
      // Restart while in RUN with a wrong Q on the START edge itself
      add(1,1,1,0,0,0, 0,0,0,0, 0,0);
      add(0,1,1,1,0,0, 1,1,0,0, 1,1);
      add(1,1,1,1,0,0, 0,0,0,0, 0,0);
      // Qn stuck equal to Q on compares 2 and 5
      add(0,1,0,0,0,0, 0,0,0,0, 1,0);
      add(0,1,1,0,0,1, 1,1,0,0, 2,1);
      add(0,1,1,0,0,0, 0,1,0,0, 3,1);
      add(0,1,0,0,0,0, 0,1,0,0, 4,1);
      add(0,1,1,0,0,1, 1,1,0,0, 5,2);
      add(0,1,0,0,0,0, 0,1,0,0, 6,2);
      add(0,1,1,0,0,0, 0,1,0,0, 7,2);
      add(0,1,0,0,0,0, 0,1,1,0, 8,2);
      add(0,1,1,0,0,1, 0,1,1,0, 8,2);

      #12;
      CLR = 1'b0;
      @(posedge CLK);
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      chk("reset_sat_chk", CHK2, 0);

      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].en, tbl[i].d, tbl[i].qf, tbl[i].qv, tbl[i].qns);
         chk_all($sformatf("row%0d", i), tbl[i].e_err, tbl[i].e_fail, tbl[i].e_done,
                 tbl[i].e_pass, tbl[i].e_chk, tbl[i].e_ec);
      end

      // EN gap of 5 cycles with Q toggling wrongly
      step(1,1,1,0,0,0);
      step(0,1,0,0,0,0);
      step(0,1,1,0,0,0);
      step(0,1,1,0,0,0);
      chk("gap_pre_chk", CHK_CNT, 3);
      for (int i = 0; i < 5; i++) begin
         step(0,0,1,1,i[0],0);
         chk($sformatf("gap%0d_chk", i), CHK_CNT, 3);
         chk($sformatf("gap%0d_ec", i), ERR_CNT, 0);
         chk($sformatf("gap%0d_err", i), ERR, 0);
      end
      step(0,1,0,0,0,0);
      chk("gap_resume_chk", CHK_CNT, 4);
      for (int i = 0; i < 4; i++) step(0,1,1,0,0,0);
      chk_all("gap_end", 0, 0, 1, 1, 8, 0);

      // Asynchronous clear mid-run with CHK_CNT=5 and ERR high
      step(1,1,1,0,0,0);
      for (int i = 0; i < 4; i++) step(0,1,1,0,0,0);
      step(0,1,1,1,0,0);
      chk_all("preclr", 1, 1, 0, 0, 5, 1);
      #2;
      CLR = 1'b1;
      #1;
      chk_all("clr_async", 0, 0, 0, 0, 0, 0);
      #2;
      CLR = 1'b0;
      step(0,1,1,0,0,0);
      chk_all("idle_after_clr", 0, 0, 0, 0, 0, 0);
      step(1,1,1,0,0,0);
      for (int i = 1; i <= 7; i++) step(0,1,i[0],0,0,0);
      chk("fresh_not_done", DONE, 0);
      step(0,1,0,0,0,0);
      chk_all("fresh_end", 0, 0, 1, 1, 8, 0);

      // Saturating instance: CNT_W=2, NUM_CHECKS=3, Q always wrong
      s2_start = 1'b1;
      @(posedge CLK); #1;
      s2_start = 1'b0;
      repeat (3) begin @(posedge CLK); #1; end
      chk("sat_ec", ECNT2, 3);
      chk("sat_chk", CHK2, 3);
      chk("sat_done", DONE2, 1);
      chk("sat_pass", PASS2, 0);
      chk("sat_fail", FAIL2, 1);
      @(posedge CLK); #1;
      chk("sat_done_err", ERR2, 0);
      chk("sat_done_hold", ECNT2, 3);
      s2_start = 1'b1;
      @(posedge CLK); #1;
      s2_start = 1'b0;
      chk("sat_rst_chk", CHK2, 0);
      chk("sat_rst_ec", ECNT2, 0);
      chk("sat_rst_done", DONE2, 0);
      chk("sat_rst_fail", FAIL2, 0);
      @(posedge CLK); #1;
      chk("sat_run_chk", CHK2, 1);
      chk("sat_run_err", ERR2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
